// File: rtl/pattern_serializer.sv
// -----------------------------------------------------------------------------
// pattern_serializer
//
// Purpose:
//   Takes parallel words on a valid/ready handshake and shifts each one out a
//   bit per clock on bit_stream. start is high for exactly one cycle, together
//   with the first bit of every word. A one-entry holding register decouples
//   the source from the shifter so that consecutive words come out back to
//   back (unless idle gap cycles are requested between words).
//
// Parameters:
//   WIDTH       bits per word (>= 2)
//   MSB_FIRST   0: word[0] goes out first, 1: word[WIDTH-1] goes out first
//   GAP_CYCLES  idle cycles (bit_stream=0, start=0) after every word, 0..255
//
// Ports:
//   clk         in   clock, everything on the rising edge
//   rst         in   synchronous reset, active high
//   in_data     in   parallel word to serialize
//   in_valid    in   in_data is valid
//   in_ready    out  holding register empty (and not in reset)
//   bit_stream  out  serial data bit, registered
//   start       out  first-bit marker, registered
//   busy        out  shifter active or a word waiting in the holding register
//   words_sent  out  number of words started on bit_stream, wraps at 16 bits
// -----------------------------------------------------------------------------
module pattern_serializer #(
  parameter int WIDTH      = 4,
  parameter int MSB_FIRST  = 0,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_stream,
  output logic             start,
  output logic             busy,
  output logic [15:0]      words_sent
);

  // Remaining-bit counter only has to hold WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic          HAS_GAP  = (GAP_CYCLES > 0);
  // The gap counter is loaded on the edge that enters GAP, so that edge
  // already accounts for the first idle cycle.
  localparam logic [7:0]    GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q,      state_d;
  logic [WIDTH-1:0] hold_q,       hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] shift_q,      shift_d;
  logic [CW-1:0]    cnt_q,        cnt_d;
  logic [7:0]       gap_q,        gap_d;
  logic             bit_q,        bit_d;
  logic             start_q,      start_d;
  logic [15:0]      words_q,      words_d;

  logic             accept;
  logic             load;

  // ---------------------------------------------------------------------------
  // Shift direction. The shifter always presents its next bit at the same
  // end, so the FSM below does not care about bit order.
  // ---------------------------------------------------------------------------
  logic             hold_first;
  logic [WIDTH-1:0] hold_rest;
  logic             shift_first;
  logic [WIDTH-1:0] shift_rest;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign hold_first  = hold_q[WIDTH-1];
      assign hold_rest   = {hold_q[WIDTH-2:0], 1'b0};
      assign shift_first = shift_q[WIDTH-1];
      assign shift_rest  = {shift_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign hold_first  = hold_q[0];
      assign hold_rest   = {1'b0, hold_q[WIDTH-1:1]};
      assign shift_first = shift_q[0];
      assign shift_rest  = {1'b0, shift_q[WIDTH-1:1]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake. in_ready depends only on the holding register and rst, never
  // on in_valid.
  // ---------------------------------------------------------------------------
  assign in_ready = ~hold_valid_q & ~rst;
  assign accept   = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    bit_d        = bit_q;
    start_d      = start_q;
    words_d      = words_q;
    load         = 1'b0;

    // Accept only happens with the holding register empty, while load only
    // happens with it full, so the two never coincide.
    if (accept) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        bit_d   = 1'b0;
        start_d = 1'b0;
        if (hold_valid_q) begin
          load = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != '0) begin
          bit_d   = shift_first;
          shift_d = shift_rest;
          cnt_d   = cnt_q - CW'(1);
          start_d = 1'b0;
        end else if (HAS_GAP) begin
          // Last bit has been on the line for a full cycle.
          state_d = ST_GAP;
          bit_d   = 1'b0;
          start_d = 1'b0;
          gap_d   = GAP_LOAD;
        end else if (hold_valid_q) begin
          // Back-to-back: next word's first bit follows immediately.
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
          bit_d   = 1'b0;
          start_d = 1'b0;
        end
      end

      ST_GAP: begin
        bit_d   = 1'b0;
        start_d = 1'b0;
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else if (hold_valid_q) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        bit_d   = 1'b0;
        start_d = 1'b0;
      end
    endcase

    // Load event: move the held word into the shifter and show its first bit.
    if (load) begin
      state_d      = ST_SHIFT;
      hold_valid_d = 1'b0;
      bit_d        = hold_first;
      start_d      = 1'b1;
      shift_d      = hold_rest;
      cnt_d        = LAST_CNT;
      words_d      = words_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset drops any word in flight and any word in the holding
  // register; nothing resumes afterwards.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      gap_q        <= 8'd0;
      bit_q        <= 1'b0;
      start_q      <= 1'b0;
      words_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      bit_q        <= bit_d;
      start_q      <= start_d;
      words_q      <= words_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bit_stream = bit_q;
  assign start      = start_q;
  assign busy       = (state_q != ST_IDLE) | hold_valid_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// -----------------------------------------------------------------------------
// tb_pattern_serializer
//
// Three serializer instances share clk and rst:
//   u_lsb : WIDTH=4, LSB first, no gap
//   u_msb : WIDTH=4, MSB first, no gap (same stimulus as u_lsb)
//   u_gap : WIDTH=4, LSB first, GAP_CYCLES=3 (own stimulus)
// Single-word cases come from a vector table; back-to-back, gap, mid-word
// reset and counter wrap are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_pattern_serializer;

  logic        clk = 1'b0;
  logic        rst;

  logic [3:0]  a_data;
  logic        a_valid;
  logic [3:0]  g_data;
  logic        g_valid;

  logic        l_ready, l_bit, l_start, l_busy;
  logic [15:0] l_words;
  logic        m_ready, m_bit, m_start, m_busy;
  logic [15:0] m_words;
  logic        g_ready, g_bit, g_start, g_busy;
  logic [15:0] g_words;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_wa;
  logic [15:0] exp_wm;
  logic [15:0] exp_wg;

  always #5 clk = ~clk;

  pattern_serializer #(.WIDTH(4), .MSB_FIRST(0), .GAP_CYCLES(0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid),
    .in_ready(l_ready), .bit_stream(l_bit), .start(l_start),
    .busy(l_busy), .words_sent(l_words)
  );

  pattern_serializer #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(0)) u_msb (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid),
    .in_ready(m_ready), .bit_stream(m_bit), .start(m_start),
    .busy(m_busy), .words_sent(m_words)
  );

  pattern_serializer #(.WIDTH(4), .MSB_FIRST(0), .GAP_CYCLES(3)) u_gap (
    .clk(clk), .rst(rst), .in_data(g_data), .in_valid(g_valid),
    .in_ready(g_ready), .bit_stream(g_bit), .start(g_start),
    .busy(g_busy), .words_sent(g_words)
  );

  // Single-word vector: expected sequences are written in time order, first
  // bit on the left (bit [3] of the literal is the first bit on the line).
  typedef struct {
    logic [3:0] data;
    logic [3:0] exp_lsb;
    logic [3:0] exp_msb;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One word from idle through u_lsb and u_msb, back to idle.
  task automatic run_word(input vec_t v);
    a_data  = v.data;
    a_valid = 1'b1;
    #1;
    check("ready_before_accept", 16'(l_ready), 16'd1);
    step();                         // accept edge
    a_valid = 1'b0;
    a_data  = ~v.data;              // data is don't-care while invalid
    check("ready_after_accept", 16'(l_ready), 16'd0);
    check("busy_hold",          16'(l_busy),  16'd1);
    check("bit_before_load",    16'(l_bit),   16'd0);
    check("start_before_load",  16'(l_start), 16'd0);
    exp_wa = exp_wa + 16'd1;
    exp_wm = exp_wm + 16'd1;
    for (int t = 0; t < 4; t++) begin
      step();
      check($sformatf("lsb_bit%0d_d%h", t, v.data), 16'(l_bit), 16'(v.exp_lsb[3-t]));
      check($sformatf("msb_bit%0d_d%h", t, v.data), 16'(m_bit), 16'(v.exp_msb[3-t]));
      check($sformatf("lsb_start%0d", t), 16'(l_start), (t == 0) ? 16'd1 : 16'd0);
      check($sformatf("msb_start%0d", t), 16'(m_start), (t == 0) ? 16'd1 : 16'd0);
      if (t == 0) begin
        check("lsb_words", l_words, exp_wa);
        check("msb_words", m_words, exp_wm);
      end
    end
    step();
    check("idle_bit",   16'(l_bit),   16'd0);
    check("idle_start", 16'(l_start), 16'd0);
    check("idle_busy",  16'(l_busy),  16'd0);
    check("idle_ready", 16'(l_ready), 16'd1);
    check("msb_idle_busy", 16'(m_busy), 16'd0);
    $display("word %h: lsb/msb serialized, words_sent=%h", v.data, l_words);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // in order:        data     lsb order  msb order
    vecs[0] = '{4'b1010, 4'b0101, 4'b1010};
    vecs[1] = '{4'b0011, 4'b1100, 4'b0011};
    vecs[2] = '{4'b1110, 4'b0111, 4'b1110};
    vecs[3] = '{4'b0001, 4'b1000, 4'b0001};
    vecs[4] = '{4'b1000, 4'b0001, 4'b1000};

    rst     = 1'b1;
    a_data  = 4'h0;
    a_valid = 1'b0;
    g_data  = 4'h0;
    g_valid = 1'b0;
    exp_wa  = 16'd0;
    exp_wm  = 16'd0;
    exp_wg  = 16'd0;

    // ---------------- reset state ----------------
    repeat (3) step();
    check("rst_bit",   16'(l_bit),   16'd0);
    check("rst_start", 16'(l_start), 16'd0);
    check("rst_ready", 16'(l_ready), 16'd0);
    check("rst_busy",  16'(l_busy),  16'd0);
    check("rst_words", l_words,      16'd0);
    check("rst_gready", 16'(g_ready), 16'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 16'(l_ready), 16'd1);
    $display("reset: outputs idle, ready=%b", l_ready);

    // ---------------- single words from the table ----------------
    for (int i = 0; i < 5; i++) begin
      run_word(vecs[i]);
    end

    // ---------------- back-to-back 4'hA then 4'h5, no gap ----------------
    begin
      logic [8:0] bits_l, bits_m, starts, readys, busys;
      bits_l = 9'b010110100;
      bits_m = 9'b101001010;
      starts = 9'b100010000;
      readys = 9'b100011111;
      busys  = 9'b111111110;
      a_data  = 4'hA;
      a_valid = 1'b1;
      step();                       // A accepted
      a_data = 4'h5;                // stalled until hold drains
      for (int c = 0; c < 9; c++) begin
        step();
        check($sformatf("b2b_bit%0d", c),   16'(l_bit),   16'(bits_l[8-c]));
        check($sformatf("b2b_mbit%0d", c),  16'(m_bit),   16'(bits_m[8-c]));
        check($sformatf("b2b_start%0d", c), 16'(l_start), 16'(starts[8-c]));
        check($sformatf("b2b_ready%0d", c), 16'(l_ready), 16'(readys[8-c]));
        check($sformatf("b2b_busy%0d", c),  16'(l_busy),  16'(busys[8-c]));
        if (c == 1) a_valid = 1'b0;  // 5 was taken at the previous edge
        $display("b2b cycle %0d: bit=%b start=%b ready=%b busy=%b", c, l_bit, l_start, l_ready, l_busy);
      end
      exp_wa = exp_wa + 16'd2;
      exp_wm = exp_wm + 16'd2;
      check("b2b_words", l_words, exp_wa);
    end

    // ---------------- GAP_CYCLES=3, words 4'hF then 4'h9 ----------------
    begin
      logic [14:0] bits, starts, readys, busys;
      bits   = 15'b111100010010000;
      starts = 15'b100000010000000;
      readys = 15'b100000011111111;
      busys  = 15'b111111111111110;
      g_data  = 4'hF;
      g_valid = 1'b1;
      step();
      g_data = 4'h9;
      for (int c = 0; c < 15; c++) begin
        step();
        check($sformatf("gap_bit%0d", c),   16'(g_bit),   16'(bits[14-c]));
        check($sformatf("gap_start%0d", c), 16'(g_start), 16'(starts[14-c]));
        check($sformatf("gap_ready%0d", c), 16'(g_ready), 16'(readys[14-c]));
        check($sformatf("gap_busy%0d", c),  16'(g_busy),  16'(busys[14-c]));
        if (c == 1) g_valid = 1'b0;
        $display("gap cycle %0d: bit=%b start=%b ready=%b busy=%b", c, g_bit, g_start, g_ready, g_busy);
      end
      exp_wg = exp_wg + 16'd2;
      check("gap_words", g_words, exp_wg);
    end

    // ---------------- reset on 2nd bit with a word in hold ----------------
    a_data  = 4'hA;
    a_valid = 1'b1;
    step();                         // A accepted
    a_data = 4'h5;
    step();                         // A loaded, first bit showing
    check("rstmid_bit0", 16'(l_bit), 16'd0);
    step();                         // 5 accepted into hold, second bit showing
    a_valid = 1'b0;
    check("rstmid_bit1", 16'(l_bit), 16'd1);
    check("rstmid_hold_ready", 16'(l_ready), 16'd0);
    rst = 1'b1;
    #1;
    check("rstmid_ready_comb", 16'(l_ready), 16'd0);
    step();
    check("rstmid_bit",   16'(l_bit),   16'd0);
    check("rstmid_start", 16'(l_start), 16'd0);
    check("rstmid_ready", 16'(l_ready), 16'd0);
    check("rstmid_busy",  16'(l_busy),  16'd0);
    check("rstmid_words", l_words,      16'd0);
    rst = 1'b0;
    exp_wa = 16'd0;
    exp_wm = 16'd0;
    exp_wg = 16'd0;
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("post_rst_bit%0d", c),   16'(l_bit),   16'd0);
      check($sformatf("post_rst_start%0d", c), 16'(l_start), 16'd0);
      check($sformatf("post_rst_busy%0d", c),  16'(l_busy),  16'd0);
    end
    $display("mid-word reset: no residual bits, words_sent=%h", l_words);

    // ---------------- words_sent wrap ----------------
    force u_lsb.words_q = 16'hFFFE;
    step();
    step();
    release u_lsb.words_q;
    #1;
    check("preload_words", l_words, 16'hFFFE);
    exp_wa = 16'hFFFE;
    run_word(vecs[0]);              // -> FFFF
    run_word(vecs[1]);              // -> 0000
    run_word(vecs[2]);              // -> 0001
    check("wrap_final", l_words, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
